// File: rtl/as2650_bus_seq.sv
// External memory bus sequencer for the AS2650 core: drives the multiplexed 8-bit pads
// through high-address latch, low-address latch and read/write strobe phases.
module as2650_bus_seq #(
  parameter int ADDR_W      = 15,
  parameter int WAIT_STATES = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  input  logic              flush_hi_i,
  output logic              ready_o,
  output logic [7:0]        rdata_o,
  output logic [7:0]        bus_o,
  input  logic [7:0]        bus_i,
  output logic              bus_dir_o,
  output logic              le_lo_o,
  output logic              le_hi_o,
  output logic              oeb_o,
  output logic              web_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, HOLD_HI, ADDR_LO, HOLD_LO, RD, WR, WR_HOLD
  } state_t;

  localparam logic [2:0] LAST_WAIT = 3'(WAIT_STATES);

  state_t      state;
  logic [15:0] addr_ext;
  logic [7:0]  hi_cache;
  logic        hi_valid;
  logic        hi_miss;
  logic [7:0]  lo_q;
  logic [7:0]  wdata_q;
  logic        we_q;
  logic [2:0]  cnt;

  // Address bits above ADDR_W-1 read as zero on the bus.
  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_W-1:0] = addr_i;
    hi_miss = !hi_valid || (addr_ext[15:8] != hi_cache);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      le_lo_o   <= 1'b0;
      le_hi_o   <= 1'b0;
      oeb_o     <= 1'b1;
      web_o     <= 1'b1;
      bus_dir_o <= 1'b1;
      bus_o     <= '0;
      ready_o   <= 1'b0;
      rdata_o   <= '0;
      hi_valid  <= 1'b0;
      hi_cache  <= '0;
      lo_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            lo_q      <= addr_ext[7:0];
            we_q      <= we_i;
            wdata_q   <= wdata_i;
            bus_dir_o <= 1'b0;
            if (hi_miss) begin
              state    <= ADDR_HI;
              bus_o    <= addr_ext[15:8];
              le_hi_o  <= 1'b1;
              hi_cache <= addr_ext[15:8];
              hi_valid <= 1'b1;
            end else begin
              state   <= ADDR_LO;
              bus_o   <= addr_ext[7:0];
              le_lo_o <= 1'b1;
            end
          end
        end
        // Hold states keep the address on the pads across each latch-enable fall.
        ADDR_HI: begin
          state   <= HOLD_HI;
          le_hi_o <= 1'b0;
        end
        HOLD_HI: begin
          state   <= ADDR_LO;
          bus_o   <= lo_q;
          le_lo_o <= 1'b1;
        end
        ADDR_LO: begin
          state   <= HOLD_LO;
          le_lo_o <= 1'b0;
        end
        HOLD_LO: begin
          cnt <= '0;
          if (we_q) begin
            state     <= WR;
            bus_o     <= wdata_q;
            bus_dir_o <= 1'b0;
            web_o     <= 1'b0;
          end else begin
            state     <= RD;
            bus_dir_o <= 1'b1;
            oeb_o     <= 1'b0;
          end
        end
        RD: begin
          if (cnt == LAST_WAIT) begin
            state   <= IDLE;
            rdata_o <= bus_i;
            oeb_o   <= 1'b1;
            ready_o <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR: begin
          if (cnt == LAST_WAIT) begin
            state <= WR_HOLD;
            web_o <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR_HOLD: begin
          state     <= IDLE;
          bus_dir_o <= 1'b1;
          ready_o   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // A flush wins over a cache load on the same edge.
      if (flush_hi_i) hi_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_as2650_bus_seq.sv
// Scoreboard bench for as2650_bus_seq: one instance with no wait states, one with two,
// driven through a shared pad/address stimulus and separate request/flush lines.
module tb_as2650_bus_seq;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  flush;
  logic        we;
  logic [14:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  bus_in;
  logic [1:0]  ready, dir, le_lo, le_hi, oeb, web;
  logic [7:0]  rdata [2];
  logic [7:0]  bus_out [2];

  int total;
  int bad;

  typedef struct {
    bit         we;
    bit         hi;
    logic [7:0] hi_b;
    logic [7:0] lo_b;
    int         lat;
    int         oeb_n;
    int         web_n;
    logic [7:0] rd;
    logic [7:0] wd;
  } exp_t;

  typedef struct {
    bit         hi;
    bit         first;
    bit         tmo;
    bit         hold_seen;
    logic [7:0] hi_b;
    logic [7:0] lo_b;
    logic [7:0] rd;
    logic [7:0] wd;
    logic [7:0] hold_d;
    logic       hold_dir;
    int         lat;
    int         oeb_n;
    int         web_n;
    int         viol;
  } obs_t;

  exp_t       sb [$];
  bit         m_valid [2];
  logic [7:0] m_hi [2];
  logic [7:0] m_rd [2];

  as2650_bus_seq #(.ADDR_W(15), .WAIT_STATES(0)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req[0]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .flush_hi_i(flush[0]), .ready_o(ready[0]), .rdata_o(rdata[0]),
    .bus_o(bus_out[0]), .bus_i(bus_in), .bus_dir_o(dir[0]), .le_lo_o(le_lo[0]),
    .le_hi_o(le_hi[0]), .oeb_o(oeb[0]), .web_o(web[0])
  );

  as2650_bus_seq #(.ADDR_W(15), .WAIT_STATES(2)) dut_ws (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req[1]), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .flush_hi_i(flush[1]), .ready_o(ready[1]), .rdata_o(rdata[1]),
    .bus_o(bus_out[1]), .bus_i(bus_in), .bus_dir_o(dir[1]), .le_lo_o(le_lo[1]),
    .le_hi_o(le_hi[1]), .oeb_o(oeb[1]), .web_o(web[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the high-byte cache and held read data; pushes one expectation.
  function automatic void predict(input int d, input bit w, input logic [14:0] a,
                                  input logic [7:0] wd, input logic [7:0] rv, input bit fl);
    exp_t       e;
    int         ws;
    logic [7:0] ah;
    ws = (d == 1) ? 2 : 0;
    ah = {1'b0, a[14:8]};
    e.we = w;
    e.hi = !m_valid[d] || (m_hi[d] != ah);
    if (e.hi) begin
      m_valid[d] = 1'b1;
      m_hi[d] = ah;
    end
    if (fl) m_valid[d] = 1'b0;
    e.hi_b = ah;
    e.lo_b = a[7:0];
    e.lat = (e.hi ? 2 : 0) + (w ? 4 : 3) + ws;
    e.oeb_n = w ? 0 : ws + 1;
    e.web_n = w ? ws + 1 : 0;
    if (!w) m_rd[d] = rv;
    e.rd = m_rd[d];
    e.wd = wd;
    sb.push_back(e);
  endfunction

  // Drives one request (entered #1 after an edge) and records what the pads did.
  task automatic access(input int d, input bit w, input logic [14:0] a, input logic [7:0] wd,
                        input logic [7:0] rv, input bit fl, output obs_t o);
    int ws;
    bit done;
    ws = (d == 1) ? 2 : 0;
    o = '{default: 0};
    we = w; addr = a; wdata = wd; bus_in = ~rv;
    req[d] = 1'b1;
    flush[d] = fl;
    @(posedge clk); #1;
    req[d] = 1'b0; flush[d] = 1'b0;
    addr = ~a; wdata = ~wd; we = ~w;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 0) o.first = le_hi[d] | le_lo[d];
      if (le_hi[d]) begin o.hi = 1'b1; o.hi_b = bus_out[d]; end
      if (le_lo[d]) o.lo_b = bus_out[d];
      if (!oeb[d]) begin
        o.oeb_n++;
        if (o.oeb_n == ws + 1) bus_in = rv;
      end
      if (!web[d]) begin
        o.web_n++;
        o.wd = bus_out[d];
      end else if (o.web_n > 0 && !o.hold_seen) begin
        o.hold_seen = 1'b1;
        o.hold_d = bus_out[d];
        o.hold_dir = dir[d];
      end
      if ((!oeb[d] && !web[d]) || (!oeb[d] && !dir[d]) || (!web[d] && dir[d]) ||
          ((le_hi[d] || le_lo[d]) && (!oeb[d] || !web[d]))) o.viol++;
      if (ready[d]) begin
        o.lat = k;
        o.rd = rdata[d];
        done = 1'b1;
      end
    end
    o.tmo = !done;
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_hi[d] = '0;
      m_rd[d] = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++; if ({le_lo[d], le_hi[d], oeb[d], web[d], dir[d], ready[d]} !== 6'b001110) begin bad++; $display("[TB] FAIL reset_strobes dut%0d got=%b exp=001110", d, {le_lo[d], le_hi[d], oeb[d], web[d], dir[d], ready[d]}); end
      total++; if (bus_out[d] !== 8'h00) begin bad++; $display("[TB] FAIL reset_bus dut%0d got=%h exp=00", d, bus_out[d]); end
      total++; if (rdata[d] !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata dut%0d got=%h exp=00", d, rdata[d]); end
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(posedge clk); #1;
  endtask

  task automatic test_first_read();
    obs_t o;
    exp_t e;
    predict(0, 1'b0, 15'h0000, 8'h00, 8'h77, 1'b0);
    access(0, 1'b0, 15'h0000, 8'h00, 8'h77, 1'b0, o);
    e = sb.pop_front();
    total++; if (o.tmo) begin bad++; $display("[TB] FAIL first_read timeout got=1 exp=0"); end
    total++; if (o.hi !== e.hi) begin bad++; $display("[TB] FAIL first_read hi_phase got=%0d exp=%0d", o.hi, e.hi); end
    total++; if (o.hi_b !== e.hi_b) begin bad++; $display("[TB] FAIL first_read hi_byte got=%h exp=%h", o.hi_b, e.hi_b); end
    total++; if (o.lo_b !== e.lo_b) begin bad++; $display("[TB] FAIL first_read lo_byte got=%h exp=%h", o.lo_b, e.lo_b); end
    total++; if (o.oeb_n !== e.oeb_n) begin bad++; $display("[TB] FAIL first_read oeb_cycles got=%0d exp=%0d", o.oeb_n, e.oeb_n); end
    total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL first_read latency got=%0d exp=%0d", o.lat, e.lat); end
    total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL first_read rdata got=%h exp=%h", o.rd, e.rd); end
    total++; if (o.viol !== 0) begin bad++; $display("[TB] FAIL first_read strobe_rules got=%0d exp=0", o.viol); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    logic [14:0] a;
    logic [7:0]  rv;
    for (int i = 1; i <= 2; i++) begin
      a = 15'(i);
      rv = 8'(8'h10 + 8'(i * 17));
      predict(0, 1'b0, a, 8'h00, rv, 1'b0);
      access(0, 1'b0, a, 8'h00, rv, 1'b0, o);
      e = sb.pop_front();
      total++; if (o.hi !== e.hi) begin bad++; $display("[TB] FAIL b2b hi_phase a=%h got=%0d exp=%0d", a, o.hi, e.hi); end
      total++; if (o.first !== 1'b1) begin bad++; $display("[TB] FAIL b2b accept_gap a=%h got=%0d exp=1", a, o.first); end
      total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL b2b latency a=%h got=%0d exp=%0d", a, o.lat, e.lat); end
      total++; if (o.lo_b !== e.lo_b) begin bad++; $display("[TB] FAIL b2b lo_byte a=%h got=%h exp=%h", a, o.lo_b, e.lo_b); end
      total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL b2b rdata a=%h got=%h exp=%h", a, o.rd, e.rd); end
    end
  endtask

  task automatic test_wrap_write();
    obs_t o;
    exp_t e;
    bit          w;
    logic [14:0] a;
    logic [7:0]  v;
    for (int i = 0; i < 2; i++) begin
      w = (i == 1);
      a = w ? 15'h0100 : 15'h00FF;
      v = w ? 8'hA5 : 8'h5C;
      predict(0, w, a, v, v, 1'b0);
      access(0, w, a, v, v, 1'b0, o);
      e = sb.pop_front();
      total++; if (o.hi !== e.hi) begin bad++; $display("[TB] FAIL wrap hi_phase a=%h got=%0d exp=%0d", a, o.hi, e.hi); end
      total++; if ({o.hi_b, o.lo_b} !== (e.hi ? {e.hi_b, e.lo_b} : {8'h00, e.lo_b})) begin bad++; $display("[TB] FAIL wrap latched_addr a=%h got=%h%h exp=%h%h", a, o.hi_b, o.lo_b, e.hi_b, e.lo_b); end
      total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL wrap latency a=%h got=%0d exp=%0d", a, o.lat, e.lat); end
      total++; if (o.web_n !== e.web_n) begin bad++; $display("[TB] FAIL wrap web_cycles a=%h got=%0d exp=%0d", a, o.web_n, e.web_n); end
      total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL wrap rdata a=%h got=%h exp=%h", a, o.rd, e.rd); end
      if (w) begin
        total++; if (o.wd !== e.wd) begin bad++; $display("[TB] FAIL wrap wdata got=%h exp=%h", o.wd, e.wd); end
        total++; if ({o.hold_seen, o.hold_dir, o.hold_d} !== {1'b1, 1'b0, e.wd}) begin bad++; $display("[TB] FAIL wrap wr_hold got=%b/%b/%h exp=1/0/%h", o.hold_seen, o.hold_dir, o.hold_d, e.wd); end
      end
      total++; if (o.viol !== 0) begin bad++; $display("[TB] FAIL wrap strobe_rules got=%0d exp=0", o.viol); end
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    exp_t e;
    bit          w;
    logic [14:0] a;
    logic [7:0]  v;
    for (int i = 0; i < 3; i++) begin
      w = (i == 2);
      a = 15'(15'h0123 + 15'(i));
      v = 8'(8'h9E + 8'(i * 37));
      predict(1, w, a, v, v, 1'b0);
      access(1, w, a, v, v, 1'b0, o);
      e = sb.pop_front();
      total++; if (o.tmo) begin bad++; $display("[TB] FAIL ws timeout a=%h got=1 exp=0", a); end
      total++; if (o.hi !== e.hi) begin bad++; $display("[TB] FAIL ws hi_phase a=%h got=%0d exp=%0d", a, o.hi, e.hi); end
      total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL ws latency a=%h got=%0d exp=%0d", a, o.lat, e.lat); end
      total++; if ({o.oeb_n, o.web_n} !== {e.oeb_n, e.web_n}) begin bad++; $display("[TB] FAIL ws strobe_cycles a=%h got=%0d/%0d exp=%0d/%0d", a, o.oeb_n, o.web_n, e.oeb_n, e.web_n); end
      total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL ws rdata a=%h got=%h exp=%h", a, o.rd, e.rd); end
      total++; if (o.viol !== 0) begin bad++; $display("[TB] FAIL ws strobe_rules got=%0d exp=0", o.viol); end
    end
  endtask

  task automatic test_flush();
    obs_t o;
    exp_t e;
    logic [14:0] a;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        m_valid[0] = 1'b0;
      end
      a = (i < 3) ? 15'(15'h0104 + 15'(i)) : 15'(15'h0300 + 15'(i));
      predict(0, 1'b0, a, 8'h00, 8'(8'hC0 + 8'(i)), i == 3);
      access(0, 1'b0, a, 8'h00, 8'(8'hC0 + 8'(i)), i == 3, o);
      e = sb.pop_front();
      total++; if (o.hi !== e.hi) begin bad++; $display("[TB] FAIL flush hi_phase step=%0d got=%0d exp=%0d", i, o.hi, e.hi); end
      total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL flush latency step=%0d got=%0d exp=%0d", i, o.lat, e.lat); end
      total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL flush rdata step=%0d got=%h exp=%h", i, o.rd, e.rd); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit          w;
    logic [14:0] a;
    logic [7:0]  v;
    bit          fl;
    for (int i = 0; i < 12; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {7'($urandom_range(1, 2)), 8'($urandom_range(0, 255))};
      v = 8'($urandom_range(0, 255));
      fl = ($urandom_range(0, 4) == 0);
      predict(0, w, a, v, v, fl);
      access(0, w, a, v, v, fl, o);
      e = sb.pop_front();
      total++; if (o.hi !== e.hi) begin bad++; $display("[TB] FAIL rand hi_phase a=%h got=%0d exp=%0d", a, o.hi, e.hi); end
      total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL rand latency a=%h got=%0d exp=%0d", a, o.lat, e.lat); end
      total++; if (o.lo_b !== e.lo_b) begin bad++; $display("[TB] FAIL rand lo_byte a=%h got=%h exp=%h", a, o.lo_b, e.lo_b); end
      total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL rand rdata a=%h got=%h exp=%h", a, o.rd, e.rd); end
      if (w) begin
        total++; if (o.wd !== e.wd) begin bad++; $display("[TB] FAIL rand wdata a=%h got=%h exp=%h", a, o.wd, e.wd); end
      end
      total++; if (o.viol !== 0) begin bad++; $display("[TB] FAIL rand strobe_rules a=%h got=%0d exp=0", a, o.viol); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      we = 1'(w); addr = 15'h0206; wdata = 8'h3C;
      req[0] = 1'b1;
      @(posedge clk); #1;
      req[0] = 1'b0;
      for (int i = 0; i < 10 && (w == 1 ? web[0] : oeb[0]); i++) begin @(posedge clk); #1; end
      total++; if ((w == 1 ? web[0] : oeb[0]) !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid reach_strobe w=%0d got=1 exp=0", w); end
      #2;
      rst = 1'b1;
      #1;
      total++; if ({le_lo[0], le_hi[0], oeb[0], web[0], dir[0], ready[0]} !== 6'b001110) begin bad++; $display("[TB] FAIL rst_mid strobes w=%0d got=%b exp=001110", w, {le_lo[0], le_hi[0], oeb[0], web[0], dir[0], ready[0]}); end
      total++; if (bus_out[0] !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid bus w=%0d got=%h exp=00", w, bus_out[0]); end
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      @(posedge clk); #1;
      predict(0, 1'b0, 15'h0206, 8'h00, 8'h6B, 1'b0);
      access(0, 1'b0, 15'h0206, 8'h00, 8'h6B, 1'b0, o);
      e = sb.pop_front();
      total++; if (o.hi !== e.hi) begin bad++; $display("[TB] FAIL rst_mid hi_phase w=%0d got=%0d exp=%0d", w, o.hi, e.hi); end
      total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL rst_mid latency w=%0d got=%0d exp=%0d", w, o.lat, e.lat); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; req = '0; flush = '0; we = 1'b0; addr = '0; wdata = '0; bus_in = '0;
    reset_model();
    test_reset();
    test_first_read();
    test_back_to_back();
    test_wrap_write();
    test_wait_states();
    test_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/as2650_bus_seq.md
Name: as2650_bus_seq

Overview:
- External memory bus sequencer for the AS2650 core; sits between the core's fetch/load/store path and the multiplexed 8-bit pads.
- Turns one core request (address, read/write, data) into the pad-level cycle that external memory and address latches consume: high-address latch phase, low-address latch phase, then a read (OEb) or write (WEb) phase.
- Caches the last latched high byte and skips the high phase when it is unchanged.

Parameters:
- ADDR_W, 15, core address width (9..16); bits above ADDR_W-1 are driven as 0 on the bus.
- WAIT_STATES, 0, extra cycles OEb/WEb is held low (0..7).

Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  asynchronous active-high reset
- req_i  input  1  core requests a bus cycle
- we_i  input  1  1 = write, 0 = read
- addr_i  input  ADDR_W  byte address
- wdata_i  input  8  write data
- flush_hi_i  input  1  invalidate cached high byte
- ready_o  output  1  one-cycle pulse: cycle complete
- rdata_o  output  8  read data, valid while ready_o=1 and held until the next read completes
- bus_o  output  8  pad output data
- bus_i  input  8  pad input data
- bus_dir_o  output  1  1 = pads are input (bus released), 0 = driving
- le_lo_o  output  1  low-address latch enable; external latch captures on its falling edge
- le_hi_o  output  1  high-address latch enable; external latch captures on its falling edge
- oeb_o  output  1  active-low memory output enable
- web_o  output  1  active-low memory write enable

Behaviour:
- All outputs are registered; posedge wb_clk_i only.
- Reset values (asynchronous, also mid-operation): state IDLE, le_lo_o=0, le_hi_o=0, oeb_o=1, web_o=1, bus_dir_o=1, bus_o=00, ready_o=0, rdata_o=00, hi cache invalid.
- States and their outputs:
  - IDLE: bus_dir_o=1, all strobes inactive.
  - ADDR_HI: bus_o=addr[15:8], bus_dir_o=0, le_hi_o=1.
  - HOLD_HI: same bus_o, le_hi_o=0.
  - ADDR_LO: bus_o=addr[7:0], le_lo_o=1.
  - HOLD_LO: same bus_o, le_lo_o=0.
  - RD: bus_dir_o=1, oeb_o=0, for WAIT_STATES+1 cycles.
  - WR: bus_o=wdata, bus_dir_o=0, web_o=0, for WAIT_STATES+1 cycles.
  - WR_HOLD: web_o=1, wdata still driven, one cycle.
- The hold states keep the address stable across each latch-enable falling edge.
- Accept: in IDLE, req_i=1 captures addr/we/wdata internally. Next state is ADDR_HI if the cache is invalid or addr[15:8] differs from the cached byte; otherwise ADDR_LO.
- Input changes after accept are ignored. Dropping req_i mid-cycle does not abort the cycle.
- The cache is loaded with addr[15:8] on entry to ADDR_HI and marked valid.
- flush_hi_i=1 invalidates the cache at the next edge and takes priority over a same-cycle load.
- RD exit: bus_i is sampled into rdata_o at the edge ending the last RD cycle. Next state is IDLE with ready_o=1 for that one cycle.
- WR exit: last WR -> WR_HOLD -> IDLE with ready_o=1.
- ready_o is asserted only in the first IDLE cycle after a completed cycle. A new req_i may be accepted in that same cycle (back-to-back).
- Latency from accept edge E0, WAIT_STATES=0:
  - read: ready_o high at E5 (high phase done) / E3 (skipped).
  - write: ready_o high at E6 / E4.
  - Each wait state adds 1.
- Never: oeb_o=0 and web_o=0 together; oeb_o=0 while bus_dir_o=0; le_* high while oeb_o or web_o is low.
- Address wrap: the core owns increments; a 0x00FF->0x0100 sequence must re-run the high phase through the cache compare.

Test Plan:
- Release reset, read req addr=0x0000 -> le_hi_o 1 cycle with bus_o=00, then le_lo_o with bus_o=00, then oeb_o=0 with bus_dir_o=1; bus_i=0x77 gives rdata_o=0x77 and ready_o at E5.
- Reads 0x0001 then 0x0002 -> no le_hi_o pulse; ready_o at E3 each; back-to-back accept in the ready cycle gives no idle gap.
- Write 0x0100 data 0xA5 after a read of 0x00FF -> le_hi_o with bus_o=01, web_o=0 for 1 cycle with bus_o=A5, A5 still driven during WR_HOLD, ready_o at E6; the external latch reconstructs 0x0100.
- WAIT_STATES=2 read -> oeb_o low 3 cycles, ready_o at E7, bus_i sampled on the last one only.
- flush_hi_i pulse, then a read at an unchanged high byte -> high phase re-executed.
- Assert wb_rst_i during RD and during WR -> outputs immediately at reset values with web_o=1 and oeb_o=1; first access after reset performs the high phase.
